// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame scan, drain and result write-back sequencer for the convolution engine
// Optional scan order: define CONV_SEQ_TOPDOWN_EN for top-row-first addressing (timing unchanged).
module conv_frame_sequencer #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int IMAGE_HEIGHT = 360,
    parameter int CONV_LATENCY = 2*ROW_SIZE+2,
    parameter int ADDR_W       = $clog2(ROW_SIZE*IMAGE_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic [WORD_SIZE-1:0] conv_pixel,
    input  logic [WORD_SIZE-1:0] conv_out,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic [15:0]          frame_cnt
);

    localparam int N    = ROW_SIZE*IMAGE_HEIGHT;
    localparam int CW   = $clog2(N+CONV_LATENCY+4);
    localparam int COLW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

    // Cycle index since start-accept: FETCH occupies 1..N, the last presented element sits at N+L+2.
    localparam logic [CW-1:0]   FETCH_LAST = CW'(N);
    localparam logic [CW-1:0]   DRAIN_LAST = CW'(N+CONV_LATENCY+2);
    localparam logic [CW-1:0]   WR_FIRST_C = CW'(CONV_LATENCY+2);
    localparam logic [CW-1:0]   WR_LAST_C  = CW'(N+CONV_LATENCY+1);
    localparam logic [COLW-1:0] COL_LAST   = COLW'(ROW_SIZE-1);

`ifdef CONV_SEQ_TOPDOWN_EN
    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
`else
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'((IMAGE_HEIGHT-1)*ROW_SIZE);
    localparam logic [ADDR_W-1:0] ROW_BACK   = ADDR_W'(2*ROW_SIZE-1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cyc_q;
    logic                   busy_q, done_q, rd_en_q, wr_en_q, vld_q;
    logic [ADDR_W-1:0]      rd_addr_q, wr_addr_q, rd_addr_d, wr_addr_d;
    logic [COLW-1:0]        rd_col_q, wr_col_q, rd_col_d, wr_col_d;
    logic [WORD_SIZE-1:0]   conv_pixel_q;
    logic [15:0]            frame_cnt_q;

    // Next scan address: step right within a row, jump to the next row at the row end.
    always_comb begin
        rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + 1'b1;
        wr_col_d = (wr_col_q == COL_LAST) ? '0 : wr_col_q + 1'b1;
`ifdef CONV_SEQ_TOPDOWN_EN
        rd_addr_d = rd_addr_q + 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
`else
        rd_addr_d = (rd_col_q == COL_LAST) ? rd_addr_q - ROW_BACK : rd_addr_q + 1'b1;
        wr_addr_d = (wr_col_q == COL_LAST) ? wr_addr_q - ROW_BACK : wr_addr_q + 1'b1;
`endif
    end

    // Frame FSM with all outputs registered; the stream and write windows are keyed off cyc_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_col_q     <= '0;
            vld_q        <= 1'b0;
            conv_pixel_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_col_q     <= '0;
            frame_cnt_q  <= '0;
        end else if (state_q == S_IDLE) begin
            if (start && !abort) begin
                state_q   <= S_FETCH;
                busy_q    <= 1'b1;
                cyc_q     <= CW'(1);
                rd_en_q   <= 1'b1;
                rd_addr_q <= ADDR_FIRST;
                rd_col_q  <= '0;
            end
        end else if (abort) begin
            // Engine contents are left stale; the next frame's warm-up window hides them.
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_col_q     <= '0;
            vld_q        <= 1'b0;
            conv_pixel_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_col_q     <= '0;
        end else begin
            cyc_q        <= cyc_q + 1'b1;
            vld_q        <= rd_en_q;
            conv_pixel_q <= vld_q ? rd_data : '0;
            if (cyc_q >= WR_FIRST_C && cyc_q <= WR_LAST_C) begin
                wr_en_q <= 1'b1;
                if (wr_en_q) begin
                    wr_addr_q <= wr_addr_d;
                    wr_col_q  <= wr_col_d;
                end else begin
                    wr_addr_q <= ADDR_FIRST;
                    wr_col_q  <= '0;
                end
            end else begin
                wr_en_q   <= 1'b0;
                wr_addr_q <= '0;
                wr_col_q  <= '0;
            end
            case (state_q)
                S_FETCH: begin
                    if (cyc_q == FETCH_LAST) begin
                        state_q   <= S_DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        rd_col_q  <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_d;
                        rd_col_q  <= rd_col_d;
                    end
                end
                S_DRAIN: begin
                    if (cyc_q == DRAIN_LAST) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cyc_q   <= '0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign conv_pixel = conv_pixel_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = conv_out;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - directed self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;

    localparam int R  = 4;
    localparam int H  = 3;
    localparam int L  = 2;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int N  = R*H;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data, conv_pixel, conv_out, wr_data;
    logic [15:0]   frame_cnt;
    logic [W-1:0]  mem [16];
    logic [W-1:0]  s1, s2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit rd_en;
        int rd_k;
        int pix_k;
        bit wr_en;
        int wr_k;
        bit busy;
        bit done;
    } vec_t;
    vec_t tbl [18];

    conv_frame_sequencer #(
        .WORD_SIZE(W), .ROW_SIZE(R), .IMAGE_HEIGHT(H), .CONV_LATENCY(L), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .conv_pixel(conv_pixel),
        .conv_out(conv_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= conv_pixel;
            s2 <= s1;
        end
    end
    assign conv_out = s2;

    function automatic int scan(int k);
`ifdef CONV_SEQ_TOPDOWN_EN
        return k;
`else
        return (H-1-k/R)*R + k%R;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts from a negedge with the DUT idle; checks every cycle of one frame against the table.
    task automatic run_frame(string tag);
        logic [27:0] act, exp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            exp = {tbl[i].busy, tbl[i].done, tbl[i].rd_en,
                   tbl[i].rd_en ? AW'(scan(tbl[i].rd_k)) : 4'h0,
                   (tbl[i].pix_k < 0) ? 8'h00 : W'(scan(tbl[i].pix_k)),
                   tbl[i].wr_en,
                   tbl[i].wr_en ? AW'(scan(tbl[i].wr_k)) : 4'h0,
                   tbl[i].wr_en ? W'(scan(tbl[i].wr_k)) : 8'h00};
            act = {busy, done, rd_en, tbl[i].rd_en ? rd_addr : 4'h0, conv_pixel, wr_en,
                   tbl[i].wr_en ? wr_addr : 4'h0, tbl[i].wr_en ? wr_data : 8'h00};
            check($sformatf("%s_c%0d", tag, i+1), 32'(act), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dcnt;
        for (int i = 0; i < 16; i++) mem[i] = W'(i);
        //            rd  rk  pix  wr  wk  busy done
        tbl[0]  = '{1'b1,  0, -1, 1'b0,  0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1,  1, -1, 1'b0,  0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1,  2,  0, 1'b0,  0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1,  3,  1, 1'b0,  0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1,  4,  2, 1'b1,  0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1,  5,  3, 1'b1,  1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1,  6,  4, 1'b1,  2, 1'b1, 1'b0};
        tbl[7]  = '{1'b1,  7,  5, 1'b1,  3, 1'b1, 1'b0};
        tbl[8]  = '{1'b1,  8,  6, 1'b1,  4, 1'b1, 1'b0};
        tbl[9]  = '{1'b1,  9,  7, 1'b1,  5, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 10,  8, 1'b1,  6, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 11,  9, 1'b1,  7, 1'b1, 1'b0};
        tbl[12] = '{1'b0,  0, 10, 1'b1,  8, 1'b1, 1'b0};
        tbl[13] = '{1'b0,  0, 11, 1'b1,  9, 1'b1, 1'b0};
        tbl[14] = '{1'b0,  0, -1, 1'b1, 10, 1'b1, 1'b0};
        tbl[15] = '{1'b0,  0, -1, 1'b1, 11, 1'b1, 1'b0};
        tbl[16] = '{1'b0,  0, -1, 1'b0,  0, 1'b1, 1'b1};
        tbl[17] = '{1'b0,  0, -1, 1'b0,  0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, rd_en, wr_en, conv_pixel, frame_cnt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Normal frame, then a quiet tail with no stray write or second done.
        run_frame("norm");
        check("norm_frame_cnt", 32'(frame_cnt), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || wr_en) dcnt++;
        end
        check("norm_tail_quiet", 32'(dcnt), 32'd0);

        // abort in IDLE, together with start, keeps the sequencer idle.
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);

        // Abort on the 6th FETCH cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", {busy, rd_en, wr_en, conv_pixel}, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd1);
        run_frame("post_abort");
        check("post_abort_frame_cnt", 32'(frame_cnt), 32'd2);

        // start held high through the frame and its done cycle.
        start = 1'b1;
        dcnt = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c <= 18 && done) dcnt++;
            if (c == 17) check("hold_done_c17", 32'(done), 32'd1);
            if (c == 18) check("hold_idle_c18", 32'(busy), 32'd0);
            if (c == 19) check("hold_restart_c19", {busy, rd_en, rd_addr}, {1'b1, 1'b1, AW'(scan(0))});
        end
        start = 1'b0;
        check("hold_one_done", 32'(dcnt), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_second_len", 32'(n), 32'd16);
        check("hold_frame_cnt", 32'(frame_cnt), 32'd4);
        @(negedge clk);

        // Asynchronous reset between edges while in DRAIN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_drain", {busy, rd_en, wr_en}, {1'b1, 1'b0, 1'b1});
        #2 rst = 1'b1;
        #1 check("async_rst_outputs",
                 {busy, done, rd_en, rd_addr, conv_pixel, wr_en, wr_addr, wr_data},
                 32'h0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("post_rst");
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller for the `convolution` engine.
- Reads one image from a pixel memory with 1-cycle read latency and streams it into the engine one pixel per clock. Scan order: bottom row first, each row left to right.
- Writes each engine result to a result memory at its image address.
- Pads the stream with zeros to drain the engine pipeline, then pulses done. Replaces testbench-driven pixel scanning in the system build.

Parameters:
- WORD_SIZE, 8, pixel width in bits
- ROW_SIZE, 540, image width in pixels (engine line-buffer length)
- IMAGE_HEIGHT, 360, image height in rows
- CONV_LATENCY, 2*ROW_SIZE+2, clocks from a pixel entering the engine to its result on outputPixel; must be ≥1
- ADDR_W, $clog2(ROW_SIZE*IMAGE_HEIGHT), pixel address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled in IDLE only
- abort  in  1  cancel the frame in progress
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result write
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  ADDR_W  pixel memory address, row*ROW_SIZE+col
- rd_data  in  WORD_SIZE  pixel memory data, valid the cycle after rd_en
- conv_pixel  out  WORD_SIZE  registered drive to engine inputPixel
- conv_out  in  WORD_SIZE  engine outputPixel
- wr_en  out  1  result memory write strobe
- wr_addr  out  ADDR_W  result address, same mapping as rd_addr
- wr_data  out  WORD_SIZE  equals conv_out, combinational
- frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; all counters 0.
- Define N = ROW_SIZE*IMAGE_HEIGHT.
- Scan index k = 0..N-1 maps to row = IMAGE_HEIGHT-1-(k / ROW_SIZE) and col = k % ROW_SIZE. Counted as row/col counters, no divider.
- State IDLE: busy=0, conv_pixel=0. On start=1, go to FETCH.
- State FETCH: rd_en=1 every cycle.
  - rd_addr walks k = 0..N-1, one index per cycle.
  - The pixel read at cycle t is registered onto conv_pixel at cycle t+2 (memory latency + output register).
  - After issuing k=N-1, go to DRAIN.
- State DRAIN: rd_en=0; conv_pixel=0 after the last real pixel has been presented.
- Presentation counter p counts cycles in which conv_pixel carries a stream element (real pixel or zero pad). Total presented = N+CONV_LATENCY.
- Writes:
  - wr_en=1 in the cycle element p is presented, for p = CONV_LATENCY .. N+CONV_LATENCY-1. This captures the result for element p-CONV_LATENCY.
  - wr_addr walks the same scan mapping, starting at k=0.
  - Exactly N writes per frame, no gaps, one per cycle.
- After the final write, go to DONE.
- State DONE: done=1 for one cycle; frame_cnt increments; then IDLE.
- start while busy: ignored, no queuing.
- start asserted in the same cycle as the done pulse: ignored. A new start is accepted from the following IDLE cycle.
- abort=1 in any busy state:
  - Next cycle: IDLE, rd_en=0, wr_en=0, conv_pixel=0.
  - No done pulse; frame_cnt unchanged.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: abort wins, stay IDLE.
- Engine pipeline contents after an abort are stale. The next frame's zero pad and CONV_LATENCY warm-up window make them irrelevant; no engine reset is issued.
- rst mid-frame: immediate IDLE, frame_cnt=0.
- Frame length: start-accept to done = N+CONV_LATENCY+3 cycles.

Optional Feature:
- Macro: CONV_SEQ_TOPDOWN_EN.
- Defined: scan is top row first, row = k / ROW_SIZE. Applies to both rd_addr and wr_addr; timing is identical.
- Undefined: bottom-row-first scan as above.

Test Plan:
All cases use ROW_SIZE=4, IMAGE_HEIGHT=3, CONV_LATENCY=2, memory preloaded with value = address, and a stub engine in which conv_out equals conv_pixel delayed 2 cycles.
- Normal frame: pulse start → rd_addr sequence 8,9,10,11,4,5,6,7,0,1,2,3. Exactly 12 wr_en cycles, contiguous. Each write has wr_data == wr_addr. done pulses once, 17 cycles after start. frame_cnt=1.
- Drain padding: same run → conv_pixel is 0 for the final 2 presentation cycles. No write occurs after wr_addr=3.
- Abort mid-frame: abort asserted on the 6th FETCH cycle → next cycle busy=0, rd_en=0, wr_en=0. No done pulse; frame_cnt unchanged. A following start produces a clean, full 12-write frame.
- Busy start / same-cycle start: start held high for the whole frame and through the done cycle → exactly one frame runs. A second frame begins only after one IDLE cycle, giving frame_cnt=2.
- Async reset mid-DRAIN: rst pulsed between clock edges → all outputs 0 immediately, before the next edge. frame_cnt=0.
- CONV_SEQ_TOPDOWN_EN defined: rd_addr sequence is 0..11 in order; write count and done timing are unchanged.
